map_diff_scanner: RTL
=====================

# map_diff_scanner

Parametrised raster scanner that walks every cell of the game grid and presents each cell's (x, y) to the game logic. It priority-encodes the returned object flags into an object code and compares that code against a shadow copy of the last-drawn frame. Only changed cells, or every cell on an init/redraw pass, are issued to the display command engine through an en_update/cmd_done handshake. It sits between the snake game logic and the display command engine and replaces the fixed 16x12, always-init scanner.

## Interface
- GRID_W, 16, grid columns
- GRID_H, 12, grid rows
- X_W, $clog2(GRID_W), x width
- Y_W, $clog2(GRID_H), y width
- NUM_OBJ, 4, object flag count; flag i maps to code i+1
- CODE_W, $clog2(NUM_OBJ+1), object code width
- clk  in  1  system clock
- nrst  in  1  reset; asynchronous, active-low
- obj_flags  in  NUM_OBJ  per-cell flags {border, apple, snakeBody, snakeHead} (bit0 = head); combinational function of x, y
- mode_pb  in  1  mode button (synchronised, one-cycle pulse)
- game_over  in  1  game-over level
- force_redraw  in  1  request full redraw at next frame start
- cmd_done  in  1  display engine finished current command
- x  out  X_W  current column
- y  out  Y_W  current row
- obj_code  out  CODE_W  encoded object of current/held cell
- diff  out  1  current cell needs drawing
- en_update  out  1  update request valid
- enable_loop  out  1  scanning active
- init_cycle  out  1  current frame is a full-redraw pass
- sync_reset  out  1  one-cycle game restart pulse
- frame_done  out  1  one-cycle pulse after last cell

## Operation
- Encoding: obj_code = i+1 for lowest set flag bit i; 0 if none. Default codes are 0 empty, 1 head, 2 body, 3 apple, 4 border.
- Raster order: x increments first; at x=GRID_W-1, x wraps to 0 and y increments; at (GRID_W-1, GRID_H-1), the scan wraps to (0,0).
- The FSM has three states: WAIT_INIT, SCAN and UPDATE.
- WAIT_INIT:
  - Entered on reset.
  - enable_loop=0, en_update=0, diff=0.
  - On cmd_done=1 (display init complete), go to SCAN at (0,0).
- SCAN:
  - enable_loop=1 and obj_code = enc(obj_flags).
  - diff = init_cycle | (obj_code != shadow[y][x]).
  - If diff=0, advance one cell per cycle.
  - If diff=1, latch obj_code, hold x and y, and go to UPDATE.
- UPDATE:
  - en_update=1, enable_loop=0, and x, y, obj_code held stable.
  - On cmd_done=1: write shadow[y][x]=held code, advance one cell, return to SCAN.
- Frame end: when advancing past the last cell, pulse frame_done.
  - init_cycle is cleared, or set again if a force_redraw is pending; pending is cleared.
- force_redraw is captured into a pending bit in any state.
- Restart: a mode_pb pulse, or a game_over rising edge, in SCAN or UPDATE:
  - sync_reset=1 for one cycle.
  - x=y=0, init_cycle=1, en_update=0.
  - State returns to SCAN; there is no WAIT_INIT.
- cmd_done outside WAIT_INIT/UPDATE is ignored.
- Shadow contents are not reset: they are don't-care because init_cycle forces diff.

## Timing
- Reset values: x=0, y=0, obj_code=0, diff=0, en_update=0, enable_loop=0, init_cycle=1, sync_reset=0, frame_done=0, state WAIT_INIT, pending=0.
- Scan throughput: one cell per clk when no diffs, so an unchanged frame takes GRID_W*GRID_H cycles.
- Update latency:
  - en_update rises the cycle after diff is seen.
  - On the cycle after cmd_done is sampled, en_update=0 and x, y have moved to the next cell.
- Minimum per-update cost is 2 cycles (SCAN + UPDATE with cmd_done already high).
- Simultaneous events:
  - Restart with cmd_done: restart wins and the shadow is not written.
  - Restart on the last cell: no frame_done.
  - force_redraw with frame end: takes effect on the frame starting now.
- Async nrst mid-UPDATE: immediate return to reset values; any pending command is abandoned.

## Structure
- Package map_scan_pkg holds:
  - state enum {WAIT_INIT, SCAN, UPDATE};
  - code constants CODE_EMPTY..CODE_BORDER;
  - the priority-encode function obj_encode().
- Sub-module map_shadow_ram: GRID_W*GRID_H x CODE_W, combinational read by {y,x}, synchronous write, no reset.
- The top level holds the FSM, coordinate counters, restart/edge logic and pending bit.

## Test plan
- Reset: nrst low 2 cycles, then cmd_done pulse -> x=0, y=0, init_cycle=1, enable_loop rises the cycle after cmd_done.
- Init pass:
  - Stimulus: border on edges only, cmd_done returned 1 cycle after each en_update.
  - Response: 192 en_update pulses, border cells code 4, others 0; one frame_done after (15,11); init_cycle=0 afterwards.
- Steady map:
  - Stimulus: after the init pass, head at (4,4) and apple at (6,4).
  - Response: exactly 2 updates, (4,4) code 1 then (6,4) code 3. The next frame has 0 updates and frame_done spacing of 192 cycles.
- Move:
  - Stimulus: switch to head (5,4), body (4,4), apple (7,4).
  - Response: updates in order (4,4)=2, (5,4)=1, (6,4)=0, (7,4)=3.
- Priority: head and border both set at (0,0) during init -> obj_code=1.
- Restart: mode_pb and cmd_done in the same UPDATE cycle at (4,4) -> sync_reset for 1 cycle, (0,0), init_cycle=1, shadow unchanged; the next frame issues 192 updates.

Source files
------------

// File: rtl/map_diff_scanner_pkg.sv
// map_scan_pkg: shared FSM states, object codes and the flag priority encoder
// used by the map difference scanner.
package map_scan_pkg;
   typedef enum logic [1:0] {WAIT_INIT, SCAN, UPDATE} state_t;
   typedef enum int {CODE_EMPTY, CODE_HEAD, CODE_BODY, CODE_APPLE, CODE_BORDER} code_t;
   // Lowest set flag wins; flag i encodes as i+1, no flag encodes as empty.
   function automatic int obj_encode(input logic [31:0] flags);
      obj_encode = CODE_EMPTY;
      for (int i = 31; i >= 0; i--) if (flags[i]) obj_encode = i + 1;
   endfunction
endpackage

// File: rtl/map_diff_scanner_if.sv
// map_diff_scanner_if: cell coordinate/code bus and the update handshake
// between the scanner (master) and the display command engine (slave).
interface map_diff_scanner_if #(
   parameter int X_W = 4,
   parameter int Y_W = 4,
   parameter int CODE_W = 3
) ();
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [CODE_W-1:0] obj_code;
   logic en_update;
   logic cmd_done;
   modport master (output x, y, obj_code, en_update, input cmd_done);
   modport slave (input x, y, obj_code, en_update, output cmd_done);
endinterface

// File: rtl/map_diff_scanner_shadow_ram.sv
// map_shadow_ram: last-drawn object code per cell; combinational read,
// synchronous write, contents intentionally left unreset.
module map_shadow_ram #(
   parameter int DEPTH = 192,
   parameter int CODE_W = 3,
   localparam int A_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [A_W-1:0]    addr_i,
   input  logic [CODE_W-1:0] wd_i,
   output logic [CODE_W-1:0] rd_o
);
   logic [CODE_W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) if (we_i) mem_q[addr_i] <= wd_i;
   assign rd_o = mem_q[addr_i];
endmodule

// File: rtl/map_diff_scanner.sv
// map_diff_scanner: raster-scans the grid, encodes each cell's object flags and
// issues only changed cells (or all cells on a redraw pass) to the display engine.
module map_diff_scanner
   import map_scan_pkg::*;
#(
   parameter int GRID_W = 16,
   parameter int GRID_H = 12,
   parameter int X_W = $clog2(GRID_W),
   parameter int Y_W = $clog2(GRID_H),
   parameter int NUM_OBJ = 4,
   parameter int CODE_W = $clog2(NUM_OBJ + 1)
) (
   input  logic               clk_i,
   input  logic               nrst_i,
   input  logic [NUM_OBJ-1:0] obj_flags_i,
   input  logic               mode_pb_i,
   input  logic               game_over_i,
   input  logic               force_redraw_i,
   map_diff_scanner_if.master bus,
   output logic               diff_o,
   output logic               enable_loop_o,
   output logic               init_cycle_o,
   output logic               sync_reset_o,
   output logic               frame_done_o
);
   localparam int DEPTH = GRID_W * GRID_H;
   localparam int A_W = $clog2(DEPTH);
   state_t state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [CODE_W-1:0] code_q, code_d, scan_code, shadow_rd;
   logic init_q, init_d, pend_q, pend_d, go_q, sync_q, sync_d, frame_q, frame_d;
   logic we, adv, last_x, last, restart;
   logic [A_W-1:0] addr;
   assign addr = A_W'(y_q) * A_W'(GRID_W) + A_W'(x_q);
   map_shadow_ram #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_shadow (
      .clk_i(clk_i), .we_i(we), .addr_i(addr), .wd_i(code_q), .rd_o(shadow_rd)
   );
   assign scan_code = CODE_W'(obj_encode(32'(obj_flags_i)));
   assign last_x = x_q == X_W'(GRID_W - 1);
   assign last = last_x && (y_q == Y_W'(GRID_H - 1));
   assign restart = (state_q != WAIT_INIT) && (mode_pb_i || (game_over_i && !go_q));
   assign diff_o = (state_q == SCAN) && (init_q || scan_code != shadow_rd);
   assign enable_loop_o = state_q == SCAN;
   assign init_cycle_o = init_q;
   assign sync_reset_o = sync_q;
   assign frame_done_o = frame_q;
   assign bus.x = x_q;
   assign bus.y = y_q;
   assign bus.obj_code = (state_q == SCAN) ? scan_code : code_q;
   assign bus.en_update = state_q == UPDATE;
   always_comb begin
      state_d = state_q;
      x_d = x_q;
      y_d = y_q;
      code_d = code_q;
      init_d = init_q;
      pend_d = pend_q || force_redraw_i;
      sync_d = 1'b0;
      frame_d = 1'b0;
      we = 1'b0;
      adv = 1'b0;
      case (state_q)
         WAIT_INIT: state_d = bus.cmd_done ? SCAN : WAIT_INIT;
         SCAN: begin
            adv = !diff_o;
            code_d = diff_o ? scan_code : code_q;
            state_d = diff_o ? UPDATE : SCAN;
         end
         UPDATE: begin
            we = bus.cmd_done;
            adv = bus.cmd_done;
            state_d = bus.cmd_done ? SCAN : UPDATE;
         end
         default: state_d = WAIT_INIT;
      endcase
      if (adv) begin
         x_d = last_x ? '0 : x_q + X_W'(1);
         y_d = last ? '0 : (last_x ? y_q + Y_W'(1) : y_q);
         frame_d = last;
         init_d = last ? pend_d : init_q;
         pend_d = last ? 1'b0 : pend_d;
      end
      // A restart overrides everything above, including a completing write.
      if (restart) begin
         state_d = SCAN;
         x_d = '0;
         y_d = '0;
         init_d = 1'b1;
         pend_d = pend_q || force_redraw_i;
         sync_d = 1'b1;
         frame_d = 1'b0;
         we = 1'b0;
      end
   end
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= WAIT_INIT;
         x_q <= '0;
         y_q <= '0;
         code_q <= '0;
         init_q <= 1'b1;
         pend_q <= 1'b0;
         go_q <= 1'b0;
         sync_q <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         y_q <= y_d;
         code_q <= code_d;
         init_q <= init_d;
         pend_q <= pend_d;
         go_q <= game_over_i;
         sync_q <= sync_d;
         frame_q <= frame_d;
      end
   end
endmodule
